// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive demultiplexer.
// No logic; no latency; no backpressure.
// Framing state is a single bit: hunting for sync, or locked to the frame.
package tdm_pkg;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    function automatic int cnt_width(input int n_ch);
        return $clog2(n_ch);
    endfunction

endpackage

// File: rtl/tdm_demux_demux1n.sv
// Decodes a channel select into a one-hot write enable for the shadow registers.
// Combinational, zero latency.
// No backpressure; en=0 forces all enables low.
module demux1n #(
    parameter int N = 4
) (
    input  logic [$clog2(N)-1:0] sel,
    input  logic                 en,
    output logic [N-1:0]         onehot
);

    localparam int SW = $clog2(N);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = en && (sel == SW'(i));
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Steers a sync-framed TDM sample stream into per-channel registers; presents whole frames.
// Latency: out_data/frame_valid register one cycle after the last channel is sampled.
// No backpressure: one sample per cycle accepted; in_valid=0 cycles are free gaps.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_sync,
    input  logic [W-1:0]    in_data,
    output logic [N_CH*W-1:0] out_data,
    output logic            frame_valid,
    output logic            locked,
    output logic            sync_err
);

    localparam int CW = cnt_width(N_CH);
    localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [W-1:0]        shadow [N_CH];
    logic [CW-1:0]       wr_sel;
    logic                wr_en;
    logic [N_CH-1:0]     wr_onehot;
    logic [N_CH*W-1:0]   frame_next;

    // A sync sample always restarts at channel 0, whatever cnt says.
    always_comb begin
        wr_sel = in_sync ? '0 : cnt;
        wr_en  = in_valid && (in_sync || (state == LOCKED && cnt != '0));
    end

    demux1n #(
        .N (N_CH)
    ) u_demux1n (
        .sel    (wr_sel),
        .en     (wr_en),
        .onehot (wr_onehot)
    );

    // The last channel bypasses its shadow so the frame completes on its own edge.
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < N_CH; k++) begin
            frame_next[k*W +: W] = (k == N_CH - 1) ? in_data : shadow[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            cnt         <= '0;
            out_data    <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                if (wr_onehot[k]) begin
                    shadow[k] <= in_data;
                end
            end
            if (in_valid) begin
                if (in_sync) begin
                    if (state == LOCKED && cnt != '0) begin
                        sync_err <= 1'b1;
                    end
                    state  <= LOCKED;
                    locked <= 1'b1;
                    cnt    <= CW'(1);
                end else if (state == LOCKED) begin
                    if (cnt == '0) begin
                        sync_err <= 1'b1;
                        state    <= HUNT;
                        locked   <= 1'b0;
                    end else if (cnt == LAST) begin
                        out_data    <= frame_next;
                        frame_valid <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with N_CH=4, W=8 and hand-computed frames.
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sync;
    logic [7:0]  in_data;
    logic [31:0] out_data;
    logic        frame_valid;
    logic        locked;
    logic        sync_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tdm_demux #(
        .N_CH (4),
        .W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sync     (in_sync),
        .in_data     (in_data),
        .out_data    (out_data),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then settle just after the edge so outputs reflect it.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input string tag, input logic fv, input logic se);
        check({tag, "_fv"}, 32'(frame_valid), 32'(fv));
        check({tag, "_se"}, 32'(sync_err), 32'(se));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = 8'h00;
        #1;
        step(0, 0, 8'h00);
        step(1, 1, 8'hEE);
        rst = 1'b0;
        check("rst_out", out_data, 32'h0);
        check("rst_locked", 32'(locked), 32'd0);
        strobes("rst", 1'b0, 1'b0);

        // Unsynced samples are dropped while hunting.
        step(1, 0, 8'h5A);
        check("hunt_locked", 32'(locked), 32'd0);
        strobes("hunt", 1'b0, 1'b0);

        // Clean frame.
        step(1, 1, 8'h11);
        check("f1_locked", 32'(locked), 32'd1);
        strobes("f1_c0", 1'b0, 1'b0);
        step(1, 0, 8'h22);
        step(1, 0, 8'h33);
        check("f1_c2_fv", 32'(frame_valid), 32'd0);
        step(1, 0, 8'h44);
        strobes("f1_done", 1'b1, 1'b0);
        check("f1_out", out_data, 32'h44332211);
        check("f1_locked2", 32'(locked), 32'd1);
        step(0, 0, 8'h00);
        check("f1_pulse", 32'(frame_valid), 32'd0);

        // Back-to-back frames.
        step(1, 1, 8'hA0);
        step(1, 0, 8'hA1);
        step(1, 0, 8'hA2);
        step(1, 0, 8'hA3);
        check("a_fv", 32'(frame_valid), 32'd1);
        check("a_out", out_data, 32'hA3A2A1A0);
        step(1, 1, 8'hB0);
        strobes("b_c0", 1'b0, 1'b0);
        step(1, 0, 8'hB1);
        step(1, 0, 8'hB2);
        check("b_mid_out", out_data, 32'hA3A2A1A0);
        step(1, 0, 8'hB3);
        check("b_fv", 32'(frame_valid), 32'd1);
        check("b_out", out_data, 32'hB3B2B1B0);

        // Idle gaps mid-frame.
        step(1, 1, 8'h01);
        step(1, 0, 8'h02);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'hFF);
            strobes("gap_idle", 1'b0, 1'b0);
        end
        step(1, 0, 8'h03);
        step(1, 0, 8'h04);
        strobes("gap_done", 1'b1, 1'b0);
        check("gap_out", out_data, 32'h04030201);

        // Early sync abandons the partial frame.
        step(1, 1, 8'h11);
        step(1, 0, 8'h22);
        step(1, 1, 8'h55);
        strobes("early", 1'b0, 1'b1);
        check("early_out", out_data, 32'h04030201);
        check("early_locked", 32'(locked), 32'd1);
        step(1, 0, 8'h66);
        check("early_se_pulse", 32'(sync_err), 32'd0);
        step(1, 0, 8'h77);
        step(1, 0, 8'h88);
        strobes("early_done", 1'b1, 1'b0);
        check("early_new_out", out_data, 32'h88776655);

        // Missing sync drops lock.
        step(1, 0, 8'h99);
        strobes("miss", 1'b0, 1'b1);
        check("miss_locked", 32'(locked), 32'd0);
        check("miss_out", out_data, 32'h88776655);
        step(1, 1, 8'h10);
        check("relock", 32'(locked), 32'd1);
        check("relock_se", 32'(sync_err), 32'd0);
        step(1, 0, 8'h20);
        step(1, 0, 8'h30);
        step(1, 0, 8'h40);
        check("relock_fv", 32'(frame_valid), 32'd1);
        check("relock_out", out_data, 32'h40302010);

        // Reset mid-frame, with a valid sample present on the reset edge.
        step(1, 1, 8'h11);
        step(1, 0, 8'h22);
        rst = 1'b1;
        step(1, 0, 8'h33);
        rst = 1'b0;
        check("mrst_out", out_data, 32'h0);
        check("mrst_locked", 32'(locked), 32'd0);
        strobes("mrst", 1'b0, 1'b0);
        step(1, 1, 8'h44);
        step(1, 0, 8'h33);
        step(1, 0, 8'h22);
        step(1, 0, 8'h11);
        check("mrst_fv", 32'(frame_valid), 32'd1);
        check("mrst_new_out", out_data, 32'h11223344);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
